// File: rtl/shared_timer_pkg.sv
// Shared types and constants for the shared delay-timer scheduler.
package shared_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_e;

  localparam logic [31:0] LOAD_DFLT = 32'd232455096;

  // Owner-index width; callers guarantee n >= 2.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/shared_timer_core.sv
// Load/decrement timer; the MSB is the expiry flag and counting stops once it sets.
module shared_timer_core #(
  parameter int Data_Width = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Load,
  input  logic [Data_Width-1:0] Load_Val,
  input  logic                  Run,
  output logic [Data_Width-1:0] Count_Val,
  output logic                  Flag
);

  logic [Data_Width-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= Load_Val;
    end else if (Run && !r_count[Data_Width-1]) begin
      r_count <= r_count - Data_Width'(1);
    end
  end

  assign Count_Val = r_count;
  assign Flag      = r_count[Data_Width-1];

endmodule

// File: rtl/shared_timer_sched.sv
// Round-robin scheduler sharing one delay timer among NUM_REQ requesters.
// Optional macro SHARED_TIMER_ABORT_EN: owner dropping Req during COUNT aborts the run.
module shared_timer_sched #(
  parameter int                    NUM_REQ    = 4,
  parameter int                    Data_Width = 32,
  parameter logic [Data_Width-1:0] LOAD_DFLT  = Data_Width'(shared_timer_pkg::LOAD_DFLT)
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*Data_Width-1:0] Load_Vals,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Done,
  output logic                          Busy,
  output logic [Data_Width-1:0]         Count_Val,
  output logic                          Flag
);

  import shared_timer_pkg::*;

  localparam int OW = clog2(NUM_REQ);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   w_winner;
  logic [OW-1:0]   w_idx;
  logic [OW-1:0]   w_ptr_nxt;
  logic            w_found;
  logic            w_load;
  logic            w_run;
  logic            w_adv;
  logic [Data_Width-1:0] w_slices [NUM_REQ];
  logic [Data_Width-1:0] w_load_val;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_slices[i] = Load_Vals[i*Data_Width +: Data_Width];
  end

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = OW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && Req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_load_val = (w_slices[w_winner] == '0) ? LOAD_DFLT : w_slices[w_winner];
  assign w_ptr_nxt  = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
`ifdef SHARED_TIMER_ABORT_EN
        if (!Req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_adv       = 1'b1;
        end else if (Flag) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_run = 1'b1;
        end
`else
        if (Flag) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_run = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_adv       = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_owner <= w_winner;
      if (w_adv)  r_ptr   <= w_ptr_nxt;
    end
  end

  shared_timer_core #(
    .Data_Width(Data_Width)
  ) u_core (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Load     (w_load),
    .Load_Val (w_load_val),
    .Run      (w_run),
    .Count_Val(Count_Val),
    .Flag     (Flag)
  );

  assign Busy  = (r_state != ST_IDLE);
  assign Grant = Busy ? (NUM_REQ'(1) << r_owner) : '0;
  assign Done  = (r_state == ST_DONE) ? (NUM_REQ'(1) << r_owner) : '0;

endmodule

// File: tb/tb_shared_timer_sched.sv
// Scoreboarded bench for shared_timer_sched: Done pulses checked against a queue of predictions.
module tb_shared_timer_sched;

  localparam int          NR   = 4;
  localparam int          DW   = 32;
  localparam logic [31:0] DFLT = 32'd232455096;

  logic             Clk;
  logic             Rst_n;
  logic [NR-1:0]    Req;
  logic [NR*DW-1:0] Load_Vals;
  logic [NR-1:0]    Grant;
  logic [NR-1:0]    Done;
  logic             Busy;
  logic [DW-1:0]    Count_Val;
  logic             Flag;

  typedef struct {
    logic [NR-1:0] vec;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            cyc;
  int            n_vec;
  int            n_err;
  logic [NR-1:0] hold;

  shared_timer_sched #(
    .NUM_REQ   (NR),
    .Data_Width(DW)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Req      (Req),
    .Load_Vals(Load_Vals),
    .Grant    (Grant),
    .Done     (Done),
    .Busy     (Busy),
    .Count_Val(Count_Val),
    .Flag     (Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Done monitor: every pulse must match the head of the prediction queue.
  always @(negedge Clk) begin
    if (Done !== '0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got %b at cycle %0d, none predicted", Done, cyc);
      end else begin
        e = exp_q.pop_front();
        if (Done !== e.vec || cyc != e.cyc) begin
          n_err++;
          $display("FAIL done_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   Done, cyc, e.vec, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      n_vec++;
      n_err++;
      e = exp_q.pop_front();
      $display("FAIL done_missing: no pulse by cycle %0d, expected %b at cycle %0d", cyc, e.vec, e.cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One cycle step; requesters drop Req on their own Done unless held.
  task automatic tick();
    @(negedge Clk);
    Req = Req & ~(Done & ~hold);
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_slice(input int i, input logic [DW-1:0] v);
    Load_Vals[i*DW +: DW] = v;
  endtask

  task automatic push(input logic [NR-1:0] vec, input int c);
    exp_t x;
    x.vec = vec;
    x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    Req   = '0;
    hold  = '0;
    tick();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Rst_n     = 1'b0;
    Req       = '0;
    Load_Vals = '0;
    hold      = '0;
    @(negedge Clk);
    n_vec += 5;
    if (Grant !== '0)     begin n_err++; $display("FAIL reset_grant: got %b expected 0", Grant); end
    if (Done !== '0)      begin n_err++; $display("FAIL reset_done: got %b expected 0", Done); end
    if (Busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Count_Val !== '0) begin n_err++; $display("FAIL reset_count: got %h expected 0", Count_Val); end
    if (Flag !== 1'b0)    begin n_err++; $display("FAIL reset_flag: got %b expected 0", Flag); end
    Rst_n = 1'b1;
    goto(cyc + 3);
    n_vec += 2;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", Busy); end
    if (Grant !== '0)  begin n_err++; $display("FAIL idle_grant: got %b expected 0", Grant); end
  endtask

  task automatic test_single();
    int t;
    do_reset();
    set_slice(1, 32'd3);
    Req = 4'b0010;
    t   = cyc;
    push(4'b0010, t + 6);
    goto(t + 1);
    n_vec += 3;
    if (Grant !== 4'b0010)  begin n_err++; $display("FAIL single_grant_start: got %b expected 0010", Grant); end
    if (Busy !== 1'b1)      begin n_err++; $display("FAIL single_busy: got %b expected 1", Busy); end
    if (Count_Val !== 32'd3) begin n_err++; $display("FAIL single_load: got %h expected 3", Count_Val); end
    set_slice(1, 32'd100);
    goto(t + 5);
    n_vec += 3;
    if (Count_Val !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL single_underflow: got %h expected ffffffff", Count_Val); end
    if (Flag !== 1'b1)      begin n_err++; $display("FAIL single_flag: got %b expected 1", Flag); end
    if (Grant !== 4'b0010)  begin n_err++; $display("FAIL single_grant_last: got %b expected 0010", Grant); end
    goto(t + 6);
    n_vec++;
    if (Grant !== 4'b0010)  begin n_err++; $display("FAIL single_grant_done: got %b expected 0010", Grant); end
    goto(t + 7);
    n_vec += 3;
    if (Busy !== 1'b0)      begin n_err++; $display("FAIL single_end_busy: got %b expected 0", Busy); end
    if (Grant !== '0)       begin n_err++; $display("FAIL single_end_grant: got %b expected 0", Grant); end
    if (Count_Val !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL single_hold: got %h expected ffffffff", Count_Val); end
  endtask

  task automatic test_contention();
    int t;
    do_reset();
    for (int i = 0; i < NR; i++) set_slice(i, 32'd5);
    Req = 4'b1111;
    t   = cyc;
    for (int k = 0; k < NR; k++) push(NR'(1) << k, t + 9*k + 8);
    for (int k = 0; k < NR; k++) begin
      goto(t + 9*k + 1);
      n_vec++;
      if (Grant !== (NR'(1) << k)) begin
        n_err++; $display("FAIL contention_grant%0d: got %b expected %b", k, Grant, NR'(1) << k);
      end
      goto(t + 9*k + 8);
      n_vec++;
      if (Grant !== (NR'(1) << k)) begin
        n_err++; $display("FAIL contention_done_grant%0d: got %b expected %b", k, Grant, NR'(1) << k);
      end
    end
    goto(t + 37);
    n_vec++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL contention_end_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_rr_fairness();
    int            t;
    logic [NR-1:0] order [4];
    order[0] = 4'b0001; order[1] = 4'b0100; order[2] = 4'b0001; order[3] = 4'b0100;
    do_reset();
    set_slice(0, 32'd2);
    set_slice(2, 32'd2);
    hold = 4'b0001;
    Req  = 4'b0101;
    t    = cyc;
    for (int k = 0; k < 4; k++) push(order[k], t + 6*k + 5);
    for (int k = 0; k < 4; k++) begin
      goto(t + 6*k + 1);
      n_vec++;
      if (Grant !== order[k]) begin
        n_err++; $display("FAIL rr_grant%0d: got %b expected %b", k, Grant, order[k]);
      end
      if (k == 1) begin
        goto(t + 12);
        Req[2] = 1'b1;
      end
    end
    goto(t + 23);
    hold   = '0;
    Req[0] = 1'b0;
    goto(t + 25);
    n_vec++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL rr_end_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_default_edge();
    int t;
    do_reset();
    set_slice(3, 32'd0);
    Req = 4'b1000;
    t   = cyc;
    goto(t + 1);
    n_vec += 2;
    if (Count_Val !== DFLT)  begin n_err++; $display("FAIL dflt_load: got %0d expected %0d", Count_Val, DFLT); end
    if (Grant !== 4'b1000)   begin n_err++; $display("FAIL dflt_grant: got %b expected 1000", Grant); end
    goto(t + 2);
    n_vec++;
    if (Count_Val !== DFLT - 32'd1) begin n_err++; $display("FAIL dflt_dec: got %0d expected %0d", Count_Val, DFLT - 32'd1); end
    goto(t + 3);
    Rst_n = 1'b0;
    Req   = '0;
    #1;
    n_vec += 3;
    if (Busy !== 1'b0)    begin n_err++; $display("FAIL midrun_busy: got %b expected 0", Busy); end
    if (Grant !== '0)     begin n_err++; $display("FAIL midrun_grant: got %b expected 0", Grant); end
    if (Count_Val !== '0) begin n_err++; $display("FAIL midrun_count: got %h expected 0", Count_Val); end
    tick();
    Rst_n = 1'b1;
    tick();
    set_slice(1, 32'h8000_0000);
    Req = 4'b0010;
    t   = cyc;
    push(4'b0010, t + 2);
    goto(t + 1);
    n_vec += 2;
    if (Flag !== 1'b1)     begin n_err++; $display("FAIL msb_flag: got %b expected 1", Flag); end
    if (Grant !== 4'b0010) begin n_err++; $display("FAIL msb_grant: got %b expected 0010", Grant); end
    goto(t + 3);
    n_vec += 2;
    if (Busy !== 1'b0)     begin n_err++; $display("FAIL msb_end_busy: got %b expected 0", Busy); end
    if (Count_Val !== 32'h8000_0000) begin n_err++; $display("FAIL msb_hold: got %h expected 80000000", Count_Val); end
  endtask

  task automatic test_abort();
    int t;
    do_reset();
    set_slice(0, 32'd10);
    Req = 4'b0001;
    t   = cyc;
`ifndef SHARED_TIMER_ABORT_EN
    push(4'b0001, t + 13);
`endif
    goto(t + 3);
    Req = '0;
    goto(t + 4);
    n_vec += 3;
`ifdef SHARED_TIMER_ABORT_EN
    if (Busy !== 1'b0)       begin n_err++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    if (Grant !== '0)        begin n_err++; $display("FAIL abort_grant: got %b expected 0", Grant); end
    if (Count_Val !== 32'd8) begin n_err++; $display("FAIL abort_hold: got %0d expected 8", Count_Val); end
`else
    if (Busy !== 1'b1)       begin n_err++; $display("FAIL noabort_busy: got %b expected 1", Busy); end
    if (Grant !== 4'b0001)   begin n_err++; $display("FAIL noabort_grant: got %b expected 0001", Grant); end
    if (Count_Val !== 32'd7) begin n_err++; $display("FAIL noabort_count: got %0d expected 7", Count_Val); end
`endif
    goto(t + 14);
    n_vec++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL abort_end_busy: got %b expected 0", Busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_contention();
    test_rr_fairness();
    test_default_edge();
    test_abort();
    goto(cyc + 2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d predicted pulses never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
